step_sequencer: RTL and testbench

Motion-command front end that sits directly upstream of the microstepper core and drives its step, dir and enable inputs.
- Accepts move commands (direction, step count, step period in clocks) over a valid/ready handshake.
- Emits step pulses with programmable width, and enforces a dir-to-step setup time.
- Tracks absolute position in microsteps.

---
 rtl/step_sequencer_pkg.sv | 25 ++
 rtl/step_period_timer.sv | 46 ++++
 rtl/step_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_step_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/step_sequencer_pkg.sv
// Shared definitions for the step sequencer.
//   - state_t : sequencer FSM states
//   - *_DFLT  : default widths for step count, step period and position
//   - move_t  : one move command {dir, steps, period}. It is used by the
//               input latch and by the optional prefetch buffer.
package step_sequencer_pkg;

  localparam int STEPS_W_DFLT  = 32;
  localparam int PERIOD_W_DFLT = 24;
  localparam int POS_W_DFLT    = 32;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DIR_SETUP  = 2'd1,
    PULSE_HIGH = 2'd2,
    PULSE_LOW  = 2'd3
  } state_t;

  typedef struct packed {
    logic                     dir;
    logic [STEPS_W_DFLT-1:0]  steps;
    logic [PERIOD_W_DFLT-1:0] period;
  } move_t;

endpackage

// File: rtl/step_period_timer.sv
// Loadable down-counter pair that times one step pulse.
// A load sets up two counts together:
//   - a pulse-width count of load_width cycles
//   - a period count of load_period cycles
// The load cycle is the first counted cycle. width_done is high on the last
// cycle of the width count. period_done is high on the last cycle of the
// period count. The period count is also reused for the dir-setup delay.
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   load          load both counters this edge
//   load_width    pulse width in cycles (>=1)
//   load_period   period in cycles (>=1)
//   width_done    last cycle of pulse width
//   period_done   last cycle of period
module step_period_timer #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                load,
  input  logic [7:0]          load_width,
  input  logic [PERIOD_W-1:0] load_period,
  output logic                width_done,
  output logic                period_done
);

  logic [7:0]          width_cnt;
  logic [PERIOD_W-1:0] period_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      width_cnt  <= 8'd0;
      period_cnt <= '0;
    end else if (load) begin
      width_cnt  <= (load_width == 8'd0) ? 8'd0 : load_width - 8'd1;
      period_cnt <= (load_period == '0) ? '0 : load_period - PERIOD_W'(1);
    end else begin
      if (width_cnt != 8'd0) width_cnt <= width_cnt - 8'd1;
      if (period_cnt != '0)  period_cnt <= period_cnt - PERIOD_W'(1);
    end
  end

  assign width_done  = (width_cnt == 8'd0);
  assign period_done = (period_cnt == '0);

endmodule

// File: rtl/step_sequencer.sv
// Motion-command front end that drives the microstepper's step/dir inputs.
// It accepts move commands and emits programmable-width step pulses at the
// commanded period. It enforces a dir-to-step setup time and tracks the
// absolute position in microsteps.
//
// Optional feature: define STEP_SEQUENCER_PREFETCH_EN to add a one-entry
// command buffer. The buffer lets the next move chain onto the current one
// with no idle cycle.
//
// Handshake: a move is transferred on a rising clk edge where
// move_valid && move_ready. The move fields are latched on that edge.
// move_valid may be held across cycles. move_ready never depends on
// move_valid. move_ready does drop combinationally while abort is high,
// because abort wins over an offered move.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   move_valid/move_ready       move command handshake
//   move_dir/steps/period       move fields (dir 1 = positive)
//   config_step_width           step high time in clocks (0 acts as 1)
//   config_dir_setup            clocks from dir change to first step rise
//   abort                       drop current and pending moves
//   step, dir                   outputs to the microstepper
//   busy                        move in progress
//   steps_remaining             steps left in current move
//   position                    signed absolute position
//   state                       FSM state, exposed for debug
module step_sequencer
  import step_sequencer_pkg::*;
#(
  parameter int STEPS_W  = STEPS_W_DFLT,
  parameter int PERIOD_W = PERIOD_W_DFLT,
  parameter int POS_W    = POS_W_DFLT
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    move_valid,
  output logic                    move_ready,
  input  logic                    move_dir,
  input  logic [STEPS_W-1:0]      move_steps,
  input  logic [PERIOD_W-1:0]     move_period,
  input  logic [7:0]              config_step_width,
  input  logic [7:0]              config_dir_setup,
  input  logic                    abort,
  output logic                    step,
  output logic                    dir,
  output logic                    busy,
  output logic [STEPS_W-1:0]      steps_remaining,
  output logic signed [POS_W-1:0] position,
  output state_t                  state
);

  logic                dir_known;
  logic [PERIOD_W-1:0] cur_period;
  move_t               incoming;
  move_t               launch_mv;
  logic                accept;
  logic                complete;
  logic                launch;
  logic                go_setup;
  logic                high_from_launch;
  logic                go_high;
  logic                next_dir;
  logic [7:0]          w_eff;
  logic [PERIOD_W-1:0] w_plus1;
  logic [PERIOD_W-1:0] p_src;
  logic [PERIOD_W-1:0] p_eff;
  logic                tmr_load;
  logic [PERIOD_W-1:0] tmr_period;
  logic                width_done;
  logic                period_done;

`ifdef STEP_SEQUENCER_PREFETCH_EN
  move_t buf_mv;
  logic  buf_valid;
  logic  buf_fill;

  assign move_ready = !buf_valid && !abort;
`else
  assign move_ready = (state == IDLE) && !abort;
`endif

  assign accept   = move_valid && move_ready;
  assign busy     = (state != IDLE);
  assign incoming = '{dir: move_dir, steps: move_steps, period: move_period};

  // Last cycle of the final period of a move.
  assign complete = (state == PULSE_LOW) && period_done && (steps_remaining == '0);

  // A move starts either from IDLE or directly out of a completing move.
  // Zero-step moves never start.
  always_comb begin
    launch    = 1'b0;
    launch_mv = incoming;
    if (state == IDLE) begin
      launch = accept && (move_steps != '0);
    end
`ifdef STEP_SEQUENCER_PREFETCH_EN
    else if (complete) begin
      if (buf_valid) begin
        launch    = 1'b1;
        launch_mv = buf_mv;
      end else begin
        launch = accept && (move_steps != '0);
      end
    end
`endif
  end

  // The setup delay is needed only when dir actually changes, or when dir
  // has never been driven since reset. A zero setup count goes straight to
  // the first pulse.
  assign go_setup = launch && ((launch_mv.dir != dir) || !dir_known) &&
                    (config_dir_setup != 8'd0);
  assign high_from_launch = launch && !go_setup;
  assign go_high = high_from_launch ||
                   ((state == DIR_SETUP) && period_done) ||
                   ((state == PULSE_LOW) && period_done && (steps_remaining != '0));
  assign next_dir = high_from_launch ? launch_mv.dir : dir;

  // Pulse timing is sampled at each pulse rise. The period is stretched so
  // that every pulse has at least one low cycle.
  assign w_eff   = (config_step_width == 8'd0) ? 8'd1 : config_step_width;
  assign w_plus1 = PERIOD_W'(w_eff) + PERIOD_W'(1);
  assign p_src   = high_from_launch ? PERIOD_W'(launch_mv.period) : cur_period;
  assign p_eff   = (p_src > w_plus1) ? p_src : w_plus1;

  assign tmr_load   = go_setup || go_high;
  assign tmr_period = go_setup ? PERIOD_W'(config_dir_setup) : p_eff;

  step_period_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk         (clk),
    .resetn      (resetn),
    .load        (tmr_load),
    .load_width  (w_eff),
    .load_period (tmr_period),
    .width_done  (width_done),
    .period_done (period_done)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= IDLE;
      step            <= 1'b0;
      dir             <= 1'b0;
      dir_known       <= 1'b0;
      steps_remaining <= '0;
      position        <= '0;
      cur_period      <= '0;
    end else if (abort) begin
      // position and dir are kept, so the host still knows where it is.
      state           <= IDLE;
      step            <= 1'b0;
      steps_remaining <= '0;
    end else begin
      if (launch) begin
        dir        <= launch_mv.dir;
        dir_known  <= 1'b1;
        cur_period <= PERIOD_W'(launch_mv.period);
      end
      if (go_setup) begin
        state           <= DIR_SETUP;
        steps_remaining <= STEPS_W'(launch_mv.steps);
      end else if (go_high) begin
        state           <= PULSE_HIGH;
        step            <= 1'b1;
        position        <= next_dir ? position + POS_W'(1) : position - POS_W'(1);
        steps_remaining <= (high_from_launch ? STEPS_W'(launch_mv.steps) : steps_remaining)
                           - STEPS_W'(1);
      end else begin
        case (state)
          PULSE_HIGH: begin
            if (width_done) begin
              step  <= 1'b0;
              state <= PULSE_LOW;
            end
          end
          PULSE_LOW: begin
            if (complete) state <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef STEP_SEQUENCER_PREFETCH_EN
  // The buffer only ever fills while a move runs. If the running move is
  // completing this cycle, an accepted move starts directly and is not
  // buffered.
  assign buf_fill = accept && (move_steps != '0) && (state != IDLE) && !complete;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_valid <= 1'b0;
      buf_mv    <= '0;
    end else if (abort) begin
      buf_valid <= 1'b0;
    end else if (buf_fill) begin
      buf_valid <= 1'b1;
      buf_mv    <= incoming;
    end else if (complete && buf_valid) begin
      buf_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_step_sequencer.sv
// Testbench for step_sequencer: directed scenarios, then randomized moves.
// A move-level reference model predicts every output on every cycle.
module tb_step_sequencer;
  import step_sequencer_pkg::*;

  localparam int STEPS_W  = 32;
  localparam int PERIOD_W = 24;
  localparam int POS_W    = 32;
`ifdef STEP_SEQUENCER_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic                move_valid, move_dir, abort;
  logic [STEPS_W-1:0]  move_steps;
  logic [PERIOD_W-1:0] move_period;
  logic [7:0]          config_step_width, config_dir_setup;
  logic                move_ready, step, dir, busy;
  logic [STEPS_W-1:0]  steps_remaining;
  logic [POS_W-1:0]    position;
  state_t              state;

  step_sequencer dut (
    .clk(clk), .resetn(resetn),
    .move_valid(move_valid), .move_ready(move_ready), .move_dir(move_dir),
    .move_steps(move_steps), .move_period(move_period),
    .config_step_width(config_step_width), .config_dir_setup(config_dir_setup),
    .abort(abort), .step(step), .dir(dir), .busy(busy),
    .steps_remaining(steps_remaining), .position(position), .state(state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [31:0] exp_q[$];
  int rise_log[$];
  int last_fall, fall_count, acc_cyc;
  bit prev_step, prev_busy, last_accept;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (move level) ----------------
  // The active move is kept as a rise schedule: first rise, period, width,
  // count. Each output is evaluated from that schedule for the current cycle.
  bit          a_on, p_on, m_dir, m_known, a_dir, p_dir;
  longint      a_first, a_end;
  int          a_steps, a_P, a_W, p_steps, p_period;
  logic [31:0] m_pos, a_pos0;

  function automatic int rises_by(input longint c);
    longint n;
    if (!a_on || c < a_first) return 0;
    n = (c - a_first) / a_P + 1;
    return (n > a_steps) ? a_steps : int'(n);
  endfunction

  // Launch a move whose first FSM cycle is cyc+1.
  task automatic model_launch(input bit d, input int s, input int per);
    bit setup;
    setup   = (d != m_dir) || !m_known;
    a_W     = (config_step_width == 8'd0) ? 1 : int'(config_step_width);
    a_P     = (per > a_W + 1) ? per : a_W + 1;
    a_first = longint'(cyc) + 1 + (setup ? longint'(config_dir_setup) : 0);
    a_end   = a_first + longint'(s) * a_P;
    a_steps = s;
    a_dir   = d;
    a_pos0  = m_pos;
    a_on    = 1'b1;
    m_dir   = d;
    m_known = 1'b1;
  endtask

  task automatic model_reset();
    a_on = 0; p_on = 0; m_dir = 0; m_known = 0; m_pos = '0;
  endtask

  // ---------------- driver: one cycle ----------------
  // Inputs are set by the caller just after posedge. Outputs are checked at
  // negedge, then the model advances across the next edge.
  task automatic tick();
    bit          exp_ready, exp_step;
    int          r;
    longint      k;
    logic [31:0] exp_pos;
    @(negedge clk);
    exp_ready = !abort && (PF ? !p_on : !a_on);
    r         = rises_by(cyc);
    exp_step  = 1'b0;
    if (a_on && longint'(cyc) >= a_first) begin
      k = longint'(cyc) - a_first;
      if (k / a_P < a_steps && k % a_P < a_W) exp_step = 1'b1;
    end
    exp_pos = a_on ? (a_dir ? a_pos0 + 32'(r) : a_pos0 - 32'(r)) : m_pos;
    check("step", step, exp_step);
    check("dir", dir, m_dir);
    check("busy", busy, a_on);
    check("move_ready", move_ready, exp_ready);
    check("steps_remaining", steps_remaining, a_on ? a_steps - r : 0);
    check("position", position, exp_pos);
    if (step && !prev_step) rise_log.push_back(cyc);
    if (!busy && prev_busy) begin last_fall = cyc; fall_count++; end
    prev_step   = step;
    prev_busy   = busy;
    last_accept = move_valid && exp_ready;
    if (last_accept) acc_cyc = cyc;
    if (abort) begin
      if (a_on) begin
        m_pos = exp_pos;
        a_on  = 1'b0;
      end
      p_on = 1'b0;
    end else begin
      if (a_on && longint'(cyc) + 1 == a_end) begin
        m_pos = a_dir ? a_pos0 + 32'(a_steps) : a_pos0 - 32'(a_steps);
        a_on  = 1'b0;
        if (p_on) begin
          model_launch(p_dir, p_steps, p_period);
          p_on = 1'b0;
        end
      end
      if (last_accept && move_steps != '0) begin
        if (!a_on) model_launch(move_dir, int'(move_steps), int'(move_period));
        else begin
          p_on = 1'b1; p_dir = move_dir;
          p_steps = int'(move_steps); p_period = int'(move_period);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input bit d, input int s, input int per);
    move_valid = 1'b1; move_dir = d;
    move_steps = STEPS_W'(s); move_period = PERIOD_W'(per);
    last_accept = 1'b0;
    for (int i = 0; i < 200 && !last_accept; i++) tick();
    check("accept_timeout", last_accept, 1'b1);
    move_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 3000 && (a_on || p_on); i++) tick();
    check("idle_timeout", a_on || p_on, 1'b0);
    tick();
  endtask

  task automatic wait_rise();
    int i;
    for (i = 0; i < 200 && rise_log.size() == 0; i++) tick();
    check("rise_timeout", rise_log.size() != 0, 1'b1);
  endtask

  task automatic check_rises(input string tag);
    check({tag, "_count"}, rise_log.size(), exp_q.size());
    while (exp_q.size() != 0 && rise_log.size() != 0)
      check(tag, rise_log.pop_front(), exp_q.pop_front());
    exp_q.delete();
    rise_log.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t, p0;
    move_valid = 0; move_dir = 0; move_steps = '0; move_period = '0;
    config_step_width = 8'd2; config_dir_setup = 8'd4; abort = 0;
    prev_step = 0; prev_busy = 0; fall_count = 0; last_fall = -1;
    model_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_step", step, 1'b0);
    check("rst_dir", dir, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", move_ready, 1'b1);
    check("rst_steps_remaining", steps_remaining, 0);
    check("rst_position", position, 0);
    check("rst_state", state, IDLE);
    resetn = 1'b1;

    // First move after reset: dir unknown, so the setup delay applies.
    send(1'b1, 3, 10);
    t = acc_cyc;
    wait_idle();
    exp_q.push_back(32'(t + 5)); exp_q.push_back(32'(t + 15)); exp_q.push_back(32'(t + 25));
    check_rises("d1_rise");
    check("d1_busy_fall", last_fall, t + 35);
    check("d1_position", position, 3);

    // Same-direction follow-up: no setup delay.
    send(1'b1, 1, 5);
    t = acc_cyc;
    wait_idle();
    exp_q.push_back(32'(t + 1));
    check_rises("d2_rise");
    check("d2_position", position, 4);

    // Period shorter than the width: P stretched to W+1 = 6.
    config_step_width = 8'd5;
    send(1'b0, 2, 3);
    t = acc_cyc;
    wait_idle();
    exp_q.push_back(32'(t + 5)); exp_q.push_back(32'(t + 11));
    check_rises("d3_rise");
    check("d3_position", position, 2);

    // Zero-step move: accepted, then dropped.
    send(1'b1, 0, 7);
    repeat (3) tick();
    check("d4_busy", busy, 1'b0);
    check("d4_ready", move_ready, 1'b1);
    check("d4_position", position, 2);
    rise_log.delete();

    // Abort on the second cycle of a pulse, with a move offered.
    config_step_width = 8'd4; config_dir_setup = 8'd0;
    send(1'b1, 100, 10);
    wait_rise();
    abort = 1'b1; move_valid = 1'b1; move_dir = 1'b1; move_steps = 32'd5;
    tick();
    abort = 1'b0; move_valid = 1'b0;
    check("d5_step", step, 1'b0);
    check("d5_busy", busy, 1'b0);
    check("d5_state", state, IDLE);
    check("d5_steps_remaining", steps_remaining, 0);
    check("d5_position", position, 3);
    repeat (2) tick();
    rise_log.delete();

`ifdef STEP_SEQUENCER_PREFETCH_EN
    // Two same-direction moves back to back: the second chains with no gap.
    config_step_width = 8'd2; config_dir_setup = 8'd3;
    send(1'b1, 3, 7);
    t = acc_cyc;
    fall_count = 0;
    send(1'b1, 2, 4);
    wait_idle();
    exp_q.push_back(32'(t + 1));  exp_q.push_back(32'(t + 8));
    exp_q.push_back(32'(t + 15)); exp_q.push_back(32'(t + 22));
    exp_q.push_back(32'(t + 26));
    check_rises("pf_rise");
    check("pf_busy_falls", fall_count, 1);
    check("pf_position", position, 8);
`endif

    // Randomized moves, configs and aborts.
    for (int i = 0; i < 3000; i++) begin
      abort = ($urandom_range(0, 149) == 0);
      if (!move_valid && $urandom_range(0, 3) == 0) begin
        move_valid  = 1'b1;
        move_dir    = 1'($urandom_range(0, 1));
        move_steps  = STEPS_W'($urandom_range(0, 5));
        move_period = PERIOD_W'($urandom_range(0, 12));
      end
      if (!a_on && $urandom_range(0, 3) == 0) begin
        config_step_width = 8'($urandom_range(0, 6));
        config_dir_setup  = 8'($urandom_range(0, 5));
      end
      tick();
      if (last_accept) move_valid = 1'b0;
    end
    abort = 1'b0; move_valid = 1'b0;
    wait_idle();

    // Reset in the middle of a pulse: outputs clear without a clock edge.
    config_step_width = 8'd3; config_dir_setup = 8'd2;
    p0 = int'(position);
    rise_log.delete();
    send(~dir, 5, 20);
    wait_rise();
    #2;
    resetn = 1'b0;
    #1;
    check("mr_step", step, 1'b0);
    check("mr_busy", busy, 1'b0);
    check("mr_dir", dir, 1'b0);
    check("mr_position", position, 0);
    check("mr_steps_remaining", steps_remaining, 0);
    check("mr_ready", move_ready, 1'b1);
    check("mr_state", state, IDLE);
    model_reset();
    @(posedge clk);
    #1;
    cyc++;
    resetn = 1'b1;
    prev_step = 0; prev_busy = 0;
    send(1'b0, 2, 4);
    wait_idle();
    check("mr_after_position", position, 32'hFFFF_FFFE);
    if (p0 == 0) check("mr_prior_position_nonzero", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
